// File: rtl/cmos_rgb565_packer.sv
// DVP byte stream to RGB565 packer: two bytes per pixel, four pixels per 64-bit DDR word.
// Capture is gated on init, sensor settle frames and frame alignment; malformed lines raise line_err.
module cmos_rgb565_packer #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        camera_pclk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        camera_vsync,
  input  logic        camera_href,
  input  logic [7:0]  camera_data,
  output logic        ddr_wren,
  output logic [63:0] ddr_data_camera,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        capture_active
);

  typedef enum logic [1:0] {WAIT_INIT, SKIP, CAPTURE} state_t;

  localparam logic [11:0] H_CNT     = 12'(H_PIXELS);
  localparam logic [11:0] V_CNT     = 12'(V_LINES);
  localparam logic [11:0] LAST_LINE = 12'(V_LINES - 1);
  localparam logic [7:0]  SKIP_CNT  = 8'(SKIP_FRAMES);

  logic        init_s1_q, init_s_q;
  logic        vs_q, vs_qq, href_q, href_qq;
  logic [7:0]  data_q;

  state_t      state_q, state_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [1:0]  pix_cnt_q, pix_cnt_d;
  logic [11:0] line_pix_q, line_pix_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [47:0] word_q, word_d;
  logic        drop_line_q, drop_line_d;
  logic        ddr_wren_q, ddr_wren_d;
  logic [63:0] ddr_data_q, ddr_data_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d;

  logic        vs_rise, href_fall, start_frame, capture_now, line_in_frame;
  logic [15:0] pixel;

  assign vs_rise       = vs_q & ~vs_qq;
  assign href_fall     = href_qq & ~href_q;
  assign capture_now   = (state_q == CAPTURE) && init_s_q;
  assign line_in_frame = line_cnt_q < V_CNT;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    start_frame = 1'b0;
    unique case (state_q)
      WAIT_INIT: begin
        if (init_s_q) begin
          state_d    = SKIP;
          skip_cnt_d = 8'd0;
        end
      end
      SKIP: begin
        if (!init_s_q) begin
          state_d = WAIT_INIT;
        end else if (vs_rise) begin
          if (skip_cnt_q == SKIP_CNT) begin
            state_d     = CAPTURE;
            start_frame = 1'b1;
          end else begin
            skip_cnt_d = skip_cnt_q + 8'd1;
          end
        end
      end
      CAPTURE: begin
        // A dropping init wins over a coincident frame edge.
        if (!init_s_q) begin
          state_d = WAIT_INIT;
        end else if (vs_rise) begin
          start_frame = 1'b1;
        end
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_comb begin
    phase_d       = phase_q;
    hi_d          = hi_q;
    pix_cnt_d     = pix_cnt_q;
    line_pix_d    = line_pix_q;
    line_cnt_d    = line_cnt_q;
    word_d        = word_q;
    drop_line_d   = drop_line_q;
    ddr_wren_d    = 1'b0;
    ddr_data_d    = ddr_data_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;
    pixel         = {hi_q, data_q};

    if (start_frame) begin
      // A frame edge in the middle of a line aborts it: the rest of that href is ignored.
      frame_start_d = 1'b1;
      line_cnt_d    = 12'd0;
      pix_cnt_d     = 2'd0;
      phase_d       = 1'b0;
      line_pix_d    = 12'd0;
      line_err_d    = href_q;
      drop_line_d   = href_q;
    end else if (!capture_now) begin
      phase_d     = 1'b0;
      pix_cnt_d   = 2'd0;
      line_pix_d  = 12'd0;
      drop_line_d = 1'b0;
    end else if (drop_line_q) begin
      if (!href_q) drop_line_d = 1'b0;
    end else if (href_q) begin
      if (!phase_q) begin
        hi_d    = data_q;
        phase_d = 1'b1;
      end else begin
        phase_d    = 1'b0;
        line_pix_d = line_pix_q + 12'd1;
        pix_cnt_d  = pix_cnt_q + 2'd1;
        word_d     = {word_q[31:0], pixel};
        if (pix_cnt_q == 2'd3 && line_in_frame) begin
          ddr_wren_d = 1'b1;
          ddr_data_d = {word_q, pixel};
        end
      end
    end else begin
      phase_d = 1'b0;
      if (href_fall) begin
        if (line_in_frame) begin
          if (phase_q || pix_cnt_q != 2'd0 || line_pix_q != H_CNT) line_err_d = 1'b1;
          if (line_cnt_q == LAST_LINE) frame_done_d = 1'b1;
          line_cnt_d = line_cnt_q + 12'd1;
        end
        pix_cnt_d  = 2'd0;
        line_pix_d = 12'd0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      init_s1_q     <= 1'b0;
      init_s_q      <= 1'b0;
      vs_q          <= 1'b0;
      vs_qq         <= 1'b0;
      href_q        <= 1'b0;
      href_qq       <= 1'b0;
      data_q        <= 8'd0;
      state_q       <= WAIT_INIT;
      skip_cnt_q    <= 8'd0;
      phase_q       <= 1'b0;
      hi_q          <= 8'd0;
      pix_cnt_q     <= 2'd0;
      line_pix_q    <= 12'd0;
      line_cnt_q    <= 12'd0;
      word_q        <= 48'd0;
      drop_line_q   <= 1'b0;
      ddr_wren_q    <= 1'b0;
      ddr_data_q    <= 64'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      init_s1_q     <= init_done;
      init_s_q      <= init_s1_q;
      vs_q          <= camera_vsync;
      vs_qq         <= vs_q;
      href_q        <= camera_href;
      href_qq       <= href_q;
      data_q        <= camera_data;
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      pix_cnt_q     <= pix_cnt_d;
      line_pix_q    <= line_pix_d;
      line_cnt_q    <= line_cnt_d;
      word_q        <= word_d;
      drop_line_q   <= drop_line_d;
      ddr_wren_q    <= ddr_wren_d;
      ddr_data_q    <= ddr_data_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign ddr_wren        = ddr_wren_q;
  assign ddr_data_camera = ddr_data_q;
  assign frame_start     = frame_start_q;
  assign frame_done      = frame_done_q;
  assign line_err        = line_err_q;
  assign capture_active  = (state_q == CAPTURE);

endmodule

// File: tb/tb_cmos_rgb565_packer.sv
// Directed-sequence bench for cmos_rgb565_packer with random pixel bytes, a frame-level
// reference model (bytes grouped into words by plain concatenation) and a word monitor.
module tb_cmos_rgb565_packer;

  localparam int H    = 32;
  localparam int V    = 6;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        ddr_wren;
  logic [63:0] ddr_data_camera;
  logic        frame_start, frame_done, line_err, capture_active;

  cmos_rgb565_packer #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIP)) dut (
    .camera_pclk    (clk),
    .rst_n          (rst_n),
    .init_done      (init_done),
    .camera_vsync   (vsync),
    .camera_href    (href),
    .camera_data    (data),
    .ddr_wren       (ddr_wren),
    .ddr_data_camera(ddr_data_camera),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .line_err       (line_err),
    .capture_active (capture_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  int          fs_cnt = 0, fd_cnt = 0;

  always @(negedge clk) begin
    if (ddr_wren) begin
      obs_q.push_back(ddr_data_camera);
      obs_cyc.push_back(cyc);
    end
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
  end

  typedef enum {M_WAIT, M_SKIP, M_CAP} mstate_t;
  mstate_t     m_state = M_WAIT;
  int          m_skip = 0, m_line = 0;
  bit          m_err = 1'b0;
  int          exp_fs = 0, exp_fd = 0;
  logic [63:0] exp_q[$];
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          mark_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_vs_rise(input bit mid_line);
    if (m_state == M_SKIP) begin
      if (m_skip == SKIP) begin
        m_state = M_CAP;
        exp_fs++;
        m_line = 0;
        m_err  = mid_line;
      end else begin
        m_skip++;
      end
    end else if (m_state == M_CAP) begin
      exp_fs++;
      m_line = 0;
      m_err  = mid_line;
    end
  endfunction

  // n_used bytes reached the packer; ends_line says the line closed normally with href falling.
  function automatic void model_line(input logic [7:0] b[$], input int n_used, input bit ends_line);
    logic [63:0] w;
    if (m_state == M_CAP && m_line < V) begin
      for (int k = 0; k < n_used / 8; k++) begin
        w = 64'd0;
        for (int j = 0; j < 8; j++) w = {w[55:0], b[8*k+j]};
        exp_q.push_back(w);
      end
      if (ends_line) begin
        if (n_used != 2 * H) m_err = 1'b1;
        if (m_line == V - 1) exp_fd++;
        m_line++;
      end
    end
  endfunction

  task automatic send_line(input int n, input bit pattern, input int vs_at);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) b.push_back(pattern ? 8'(i % 8 + 1) : 8'($urandom));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = b[i];
      if (vs_at >= 0 && i == vs_at) vsync = 1'b1;
      if (vs_at >= 0 && i == vs_at + 3) vsync = 1'b0;
      if (i == 7) mark_cyc = cyc;
    end
    @(negedge clk);
    href = 1'b0;
    data = 8'd0;
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    if (vs_at >= 0) begin
      model_line(b, vs_at, 1'b0);
      model_vs_rise(1'b1);
    end else begin
      model_line(b, n, 1'b1);
    end
  endtask

  task automatic send_vsync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    model_vs_rise(1'b0);
  endtask

  task automatic send_frame();
    send_vsync();
    repeat (V) send_line(2 * H, 1'b0, -1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wren"}, ddr_wren, 0);
    check({tag, "_data"}, ddr_data_camera, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_err"}, line_err, 0);
    check({tag, "_cap"}, capture_active, 0);
  endtask

  task automatic wait_init_synced();
    repeat (5) @(negedge clk);
    m_state = M_SKIP;
    m_skip  = 0;
  endtask

  initial begin
    logic [7:0] b[$];
    int         drop_cyc;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Frames sent before init must not be captured.
    send_frame();
    check_words("no_init");
    check("no_init_fs", 64'(fs_cnt), 64'(exp_fs));

    // Settle frames: frame_start only on the (SKIP+1)th frame edge.
    init_done = 1'b1;
    wait_init_synced();
    send_frame();
    send_frame();
    check("skip_fs", 64'(fs_cnt), 64'(exp_fs));
    check("skip_cap", capture_active, 0);
    check_words("skip");
    send_vsync();
    check("enter_fs", 64'(fs_cnt), 64'(exp_fs));
    check("enter_cap", capture_active, 1);

    // Packing order and write latency on a known byte pattern.
    send_line(2 * H, 1'b1, -1);
    check("latency", obs_cyc.size() > 0 ? 64'(obs_cyc[0] - mark_cyc) : 64'hdead, 2);
    check("pack_word", obs_q.size() > 0 ? obs_q[0] : 64'hdead, 64'h0102030405060708);
    check_words("pack");

    // Rest of the frame, then one extra line past V_LINES.
    repeat (V - 1) send_line(2 * H, 1'b0, -1);
    check("frame_fd", 64'(fd_cnt), 64'(exp_fd));
    check("frame_err", line_err, m_err);
    check_words("frame");
    send_line(2 * H, 1'b0, -1);
    check_words("beyond");
    check("beyond_fd", 64'(fd_cnt), 64'(exp_fd));

    // Short line: odd byte count flags line_err and drops the partial word.
    send_vsync();
    send_line(2 * H - 1, 1'b0, -1);
    check("short_err", line_err, m_err);
    check_words("short");
    repeat (V - 1) send_line(2 * H, 1'b0, -1);
    check("short_err_sticky", line_err, m_err);
    check_words("short_rest");
    send_vsync();
    check("clear_err", line_err, m_err);
    check("clear_fs", 64'(fs_cnt), 64'(exp_fs));

    // Frame edge mid-line aborts the line and restarts the frame with line_err set.
    send_line(2 * H, 1'b0, 20);
    check("abort_err", line_err, m_err);
    check("abort_fs", 64'(fs_cnt), 64'(exp_fs));
    check_words("abort");
    repeat (V) send_line(2 * H, 1'b0, -1);
    check("abort_fd", 64'(fd_cnt), 64'(exp_fd));
    check("abort_err_kept", line_err, m_err);
    check_words("abort_frame");

    // init_done drops mid-line: writes stop within 3 cycles and capture ends.
    send_vsync();
    b.delete();
    for (int i = 0; i < 2 * H; i++) b.push_back(8'($urandom));
    drop_cyc = 0;
    for (int i = 0; i < 2 * H; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = b[i];
      if (i == 24) begin
        init_done = 1'b0;
        drop_cyc  = cyc;
      end
    end
    @(negedge clk);
    href = 1'b0;
    repeat (6) @(negedge clk);
    model_line(b, 24, 1'b0);
    m_state = M_WAIT;
    check("drop_cap", capture_active, 0);
    check("drop_stop", obs_cyc.size() > 0 ? 64'(obs_cyc[obs_cyc.size()-1] <= drop_cyc + 3) : 64'd0, 1);
    check_words("drop");

    // Re-init runs the whole skip sequence again.
    init_done = 1'b1;
    wait_init_synced();
    send_frame();
    send_frame();
    check("reinit_skip_fs", 64'(fs_cnt), 64'(exp_fs));
    send_frame();
    check("reinit_fs", 64'(fs_cnt), 64'(exp_fs));
    check("reinit_fd", 64'(fd_cnt), 64'(exp_fd));
    check("reinit_err", line_err, m_err);
    check_words("reinit");

    // Asynchronous reset mid-line clears every output at once.
    send_vsync();
    b.delete();
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = b[i];
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    model_line(b, 12, 1'b0);
    check_words("pre_rst");
    @(negedge clk);
    href = 1'b0;
    m_state = M_WAIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init_synced();
    send_frame();
    check("post_rst_cap", capture_active, 0);
    check("post_rst_fs", 64'(fs_cnt), 64'(exp_fs));
    check_words("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
